// File: rtl/dma_arb_pkg.sv
// ---------------------------------------------------------------------------
// dma_arb_pkg
// Shared constants and types for the 8237A-style DMA request/acknowledge
// front end (dma_priority_arbiter and its helpers).
//   NCH / CW            : channel count and channel index width
//   arb_state_e         : grant FSM states (IDLE, LOCK)
//   REQ_*               : field positions inside the request-register write word
//   CMD_*               : commandReg bit positions for the control inputs
// ---------------------------------------------------------------------------
package dma_arb_pkg;

  localparam int NCH = 4;
  localparam int CW  = 2;

  // IDLE: no grant held. LOCK: one channel granted and frozen until it is
  // serviced or withdrawn before acknowledge.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Request-register write word: [2] set/clear, [1:0] channel.
  localparam int REQ_SET_BIT = 2;
  localparam int REQ_CH_MSB  = 1;
  localparam int REQ_CH_LSB  = 0;

  // commandReg bits that feed this block as individual inputs.
  localparam int CMD_DISABLE_BIT   = 2;
  localparam int CMD_ROTATE_BIT    = 4;
  localparam int CMD_DREQ_LOW_BIT  = 6;
  localparam int CMD_DACK_HIGH_BIT = 7;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_arb_if
// Handshake between the request arbiter and the DMA timing-control FSM.
//   valid_dreq : one-hot granted request (arbiter -> FSM)
//   sel_chan   : granted channel index, valid while busy (arbiter -> FSM)
//   busy       : grant locked (arbiter -> FSM)
//   valid_dack : FSM is in its S1 acknowledge window (FSM -> arbiter)
//   svc_done   : one-cycle service-complete / EOP-abort pulse (FSM -> arbiter)
// master = arbiter side, slave = timing FSM side.
// ---------------------------------------------------------------------------
interface dma_arb_if #(
  parameter int NCH = 4,
  parameter int CW  = 2
);

  logic [NCH-1:0] valid_dreq;
  logic [CW-1:0]  sel_chan;
  logic           busy;
  logic           valid_dack;
  logic           svc_done;

  modport master (
    output valid_dreq,
    output sel_chan,
    output busy,
    input  valid_dack,
    input  svc_done
  );

  modport slave (
    input  valid_dreq,
    input  sel_chan,
    input  busy,
    output valid_dack,
    output svc_done
  );

endinterface

// File: rtl/dma_prio_pick.sv
// ---------------------------------------------------------------------------
// dma_prio_pick
// Combinational priority picker.
//   req    in  NCH : effective requests
//   ptr    in  CW  : highest-priority channel when rotating
//   rotate in  1   : 1 = search from ptr with wrap, 0 = fixed (ch0 highest)
//   any    out 1   : at least one request present
//   idx    out CW  : winning channel index (0 when any=0)
// The wrap relies on NCH being a power of two so CW-bit addition is mod NCH.
// ---------------------------------------------------------------------------
module dma_prio_pick #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  input  logic           rotate,
  output logic           any,
  output logic [CW-1:0]  idx
);

  logic [CW-1:0] start;
  logic [CW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requesting channel
  // (relative to the start point) is the last one written and wins.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    cand  = '0;
    start = rotate ? ptr : '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = start + CW'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
// Request/acknowledge front end of an 8237A-style DMA controller. Samples
// DREQ, keeps the software request register, applies mask/polarity/disable,
// arbitrates (fixed or rotating) and holds one grant until the timing FSM
// reports service complete. Drives DACK from the FSM's acknowledge window.
//   CLK, RESET      : clock, synchronous active-high reset
//   DREQ            : raw request pins (asynchronous)
//   cmd_disable     : blocks all new grants
//   cmd_rotate      : 1 rotating priority, 0 fixed
//   cmd_dreq_low    : DREQ active-low
//   cmd_dack_high   : DACK active-high
//   mask            : per-channel hardware DREQ mask
//   req_wr/_data    : software request register write ([2] set, [1:0] chan)
//   fsm             : handshake with the timing FSM (dma_arb_if.master)
//   DACK            : acknowledge pins
//   req_status      : pending requests for statusReg[7:4]
// ---------------------------------------------------------------------------
module dma_priority_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NCH = dma_arb_pkg::NCH,
  parameter int CW  = dma_arb_pkg::CW
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NCH-1:0]  DREQ,
  input  logic            cmd_disable,
  input  logic            cmd_rotate,
  input  logic            cmd_dreq_low,
  input  logic            cmd_dack_high,
  input  logic [NCH-1:0]  mask,
  input  logic            req_wr,
  input  logic [2:0]      req_wr_data,
  dma_arb_if.master       fsm,
  output logic [NCH-1:0]  DACK,
  output logic [NCH-1:0]  req_status
);

  arb_state_e     state_q, state_d;
  logic [NCH-1:0] dreq_s_q, dreq_s_d;
  logic [NCH-1:0] sw_req_q, sw_req_d;
  logic [NCH-1:0] dack_int_q, dack_int_d;
  logic [NCH-1:0] valid_dreq_q, valid_dreq_d;
  logic [CW-1:0]  sel_chan_q, sel_chan_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic           acked_q, acked_d;

  logic [NCH-1:0] hw_req;
  logic [NCH-1:0] eff_req;
  logic           pick_any;
  logic [CW-1:0]  pick_idx;
  logic [CW-1:0]  wr_chan;
  logic           wr_set;

  assign wr_chan = req_wr_data[REQ_CH_MSB:REQ_CH_LSB];
  assign wr_set  = req_wr_data[REQ_SET_BIT];

  // Normalise DREQ to active-high before the single sync stage; masking
  // applies only to hardware requests, software requests bypass it.
  always_comb begin
    dreq_s_d = DREQ ^ {NCH{cmd_dreq_low}};
    hw_req   = dreq_s_q & ~mask;
    eff_req  = (hw_req | sw_req_q) & ~{NCH{cmd_disable}};
  end

  // Software request register. The write is applied after the service
  // clear so a write to the channel being completed takes effect.
  always_comb begin
    sw_req_d = sw_req_q;
    if (fsm.svc_done) begin
      sw_req_d[sel_chan_q] = 1'b0;
    end
    if (req_wr) begin
      sw_req_d[wr_chan] = wr_set;
    end
  end

  dma_prio_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_pick (
    .req    (eff_req),
    .ptr    (ptr_q),
    .rotate (cmd_rotate),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Grant FSM. In LOCK the grant is frozen; it is released either by the
  // service-complete pulse or by the request disappearing before the FSM
  // ever acknowledged it. Only a completed service advances the rotate
  // pointer, so an aborted request keeps its place in the order.
  always_comb begin
    state_d      = state_q;
    sel_chan_d   = sel_chan_q;
    valid_dreq_d = valid_dreq_q;
    dack_int_d   = dack_int_q;
    acked_d      = acked_q;
    ptr_d        = ptr_q;
    case (state_q)
      IDLE: begin
        valid_dreq_d = '0;
        dack_int_d   = '0;
        if (pick_any) begin
          state_d      = LOCK;
          sel_chan_d   = pick_idx;
          valid_dreq_d = NCH'(1) << pick_idx;
          acked_d      = 1'b0;
        end
      end
      LOCK: begin
        dack_int_d = valid_dreq_q & {NCH{fsm.valid_dack}};
        if (fsm.valid_dack) begin
          acked_d = 1'b1;
        end
        if (fsm.svc_done) begin
          state_d      = IDLE;
          valid_dreq_d = '0;
          dack_int_d   = '0;
          acked_d      = 1'b0;
          if (cmd_rotate) begin
            ptr_d = sel_chan_q + CW'(1);
          end
        end else if (!acked_q && !eff_req[sel_chan_q]) begin
          state_d      = IDLE;
          valid_dreq_d = '0;
          dack_int_d   = '0;
          acked_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      dreq_s_q     <= '0;
      sw_req_q     <= '0;
      dack_int_q   <= '0;
      valid_dreq_q <= '0;
      sel_chan_q   <= '0;
      ptr_q        <= '0;
      acked_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dreq_s_q     <= dreq_s_d;
      sw_req_q     <= sw_req_d;
      dack_int_q   <= dack_int_d;
      valid_dreq_q <= valid_dreq_d;
      sel_chan_q   <= sel_chan_d;
      ptr_q        <= ptr_d;
      acked_q      <= acked_d;
    end
  end

  assign fsm.valid_dreq = valid_dreq_q;
  assign fsm.sel_chan   = sel_chan_q;
  assign fsm.busy       = (state_q == LOCK);
  assign DACK           = cmd_dack_high ? dack_int_q : ~dack_int_q;
  assign req_status     = dreq_s_q | sw_req_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Request/acknowledge front end of the 8237A-style DMA controller, directly upstream of the DMA timing-control FSM.
- Samples the four DREQ pins and maintains the software request register.
- Applies mask, polarity and controller-disable settings, then arbitrates using fixed or rotating priority.
- Holds one granted channel stable as a one-hot valid_dreq until the timing FSM reports service complete, and drives the per-channel DACK pins from the FSM's valid_dack strobe.

Parameters:
- NCH, 4, number of DMA channels; the design is verified at 4 only.
- CW, 2, channel index width, equal to $clog2(NCH).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  NCH  raw DMA request pins, asynchronous.
- cmd_disable  in  1  commandReg[2]; 1 blocks all new grants.
- cmd_rotate  in  1  commandReg[4]; 1 selects rotating priority, 0 selects fixed (ch0 highest).
- cmd_dreq_low  in  1  commandReg[6]; 1 means DREQ is active-low.
- cmd_dack_high  in  1  commandReg[7]; 1 means DACK is active-high.
- mask  in  NCH  mask register; 1 blocks hardware DREQ on that channel.
- req_wr  in  1  single-cycle write strobe for the request register.
- req_wr_data  in  3  [2] is set(1)/clear(0), [1:0] is the channel.
- valid_dack  in  1  from the timing FSM; high during the S1 acknowledge window.
- svc_done  in  1  from the timing FSM; one-cycle pulse in S4 or on EOP abort.
- valid_dreq  out  NCH  one-hot granted request to the timing FSM.
- sel_chan  out  CW  granted channel index; valid while busy=1.
- busy  out  1  grant locked.
- DACK  out  NCH  acknowledge pins, polarity per cmd_dack_high.
- req_status  out  NCH  pending requests for statusReg[7:4].

Behaviour:
- **Reset** (RESET=1 at a CLK edge) clears the following. RESET has priority over every other input in the same cycle, including mid-service.
  - Sync flops, sw_req, dack_int, valid_dreq, sel_chan and busy all go to 0.
  - Rotate pointer goes to 0.
  - State goes to IDLE.
  - DACK shows the inactive level for the current cmd_dack_high (all 1s when cmd_dack_high=0).
- **DREQ sampling:**
  - One sync flop per pin: dreq_s <= DREQ ^ {NCH{cmd_dreq_low}}.
  - hw_req = dreq_s & ~mask.
  - eff_req = (hw_req | sw_req) & ~{NCH{cmd_disable}}. Software requests ignore mask.
  - req_status = dreq_s | sw_req, registered-path values, unmasked.
- **Request register:**
  - On req_wr, sw_req[req_wr_data[1:0]] <= req_wr_data[2].
  - On svc_done, sw_req[sel_chan] <= 0.
  - If both happen on the same channel in the same cycle, req_wr wins.
- **FSM, two states, binary encoded:**
  - IDLE: busy=0 and valid_dreq=0. If eff_req != 0, the winner is registered into sel_chan, valid_dreq = 1<<winner, busy=1, and the state moves to LOCK. Latency from DREQ edge to valid_dreq is 2 CLK edges.
  - LOCK: sel_chan and valid_dreq are frozen; new or higher-priority requests are ignored.
    - dack_int <= valid_dreq & {NCH{valid_dack}}, registered, so DACK follows valid_dack by one cycle.
    - Once valid_dack has been seen (flag acked), the grant is held until svc_done even if DREQ drops.
  - LOCK exits to IDLE on either of:
    - svc_done: valid_dreq, busy and dack_int clear on that edge. If cmd_rotate=1, pointer <= sel_chan+1 mod NCH, making the served channel lowest priority.
    - Abort: acked=0 and eff_req[sel_chan]=0. The request was withdrawn before acknowledge, so the state returns to IDLE with no pointer update.
  - A new grant can occur on the cycle after return to IDLE. No back-to-back grant happens on the svc_done edge.
- **Priority:**
  - Fixed mode: lowest index wins.
  - Rotating mode: search starts at pointer and wraps modulo NCH.
  - Pointer retains its value when cmd_rotate=0.
- **DACK output:** DACK = cmd_dack_high ? dack_int : ~dack_int, combinational from dack_int.

Decomposition:
- Package dma_arb_pkg holds:
  - the NCH/CW constants;
  - the arb_state_e enum {IDLE, LOCK};
  - the request-register write field positions (set bit 2, channel bits 1:0);
  - the commandReg bit indices 2, 4, 6 and 7.
- One combinational sub-module dma_prio_pick picks the winner:
  - inputs: req[NCH], ptr[CW], rotate;
  - outputs: any, idx[CW].

Test Plan:
- **Fixed priority:** cmd=0, mask=0, DREQ=4'b1010 at edge 0 -> valid_dreq=4'b0010 and sel_chan=1 after edge 2. DREQ[0] rising while in LOCK -> grant stays on ch1 until svc_done.
- **Rotating priority:** cmd_rotate=1, DREQ=4'b1111, complete 4 services with valid_dack then svc_done -> grant order 0,1,2,3, then 0 again.
- **Masking and software request:** mask=4'b0001, DREQ[0]=1 -> no grant, req_status[0]=1. Then req_wr with data 3'b100 -> ch0 granted. svc_done -> sw_req[0]=0.
- **Polarity:** cmd_dreq_low=1, cmd_dack_high=1, DREQ=4'b1011 -> ch2 granted. valid_dack=1 -> DACK=4'b0100 one cycle later, all 0 otherwise.
- **Abort and reset:**
  - DREQ[3] withdrawn in LOCK before valid_dack -> IDLE with pointer unchanged.
  - Separately, RESET asserted mid-LOCK with DACK active -> next cycle busy=0, valid_dreq=0, DACK=4'b1111 (cmd_dack_high=0), sw_req=0.
- **Disable:** cmd_disable=1 with DREQ=4'b1111 -> no grant for 10 cycles. Clearing it -> ch0 granted 1 cycle later.
